ex_divider: RTL and testbench

- Iterative 32-bit integer divider in the EX stage, alongside the single-cycle ALU.
- Executes LA32R DIV.W, MOD.W, DIV.WU and MOD.WU.
- Receives the same EX operands as the ALU and returns a quotient or remainder to the EX result mux.
- Uses a valid/ready handshake on both sides so the pipeline stalls while a division is in flight.

---
 rtl/ex_divider.sv | 132 +++++++++++++
 tb/tb_ex_divider.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_divider.sv
// Iterative restoring divider for LA32R DIV.W/MOD.W/DIV.WU/MOD.WU in the EX stage.
// It takes one quotient bit per cycle, and its valid/ready handshakes stall the pipeline while it runs.
module ex_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] y_reg;
  logic             mod_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;

  logic             accept;
  logic             is_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] y_zero;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] y_calc;

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign y         = y_reg;
  assign accept    = in_valid && in_ready;

  assign is_signed = ~op[1];
  assign a_mag     = (is_signed && a[WIDTH-1]) ? (~a + ONE) : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? (~b + ONE) : b;
  assign y_zero    = op[0] ? a : {WIDTH{1'b1}};

  // The partial remainder can reach 2*divisor-1 for large unsigned divisors, so the trial needs one extra bit.
  assign shifted  = {rem_reg, dvd_reg[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, dvs_reg});
  assign rem_step = ge ? (shifted[WIDTH-1:0] - dvs_reg) : shifted[WIDTH-1:0];
  assign quo_step = {quo_reg[WIDTH-2:0], ge};

  assign q_fix  = neg_q_reg ? (~quo_step + ONE) : quo_step;
  assign r_fix  = neg_r_reg ? (~rem_step + ONE) : rem_step;
  assign y_calc = mod_reg ? r_fix : q_fix;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      dvd_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      y_reg     <= '0;
      mod_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (flush) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            mod_reg   <= op[0];
            neg_q_reg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_reg <= is_signed && a[WIDTH-1];
            dvd_reg   <= a_mag;
            dvs_reg   <= b_mag;
            rem_reg   <= '0;
            quo_reg   <= '0;
            cnt_reg   <= '0;
            if (b == '0) begin
              y_reg     <= y_zero;
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
          if (cnt_reg == LAST_CNT) begin
            // Sign fix-up is folded into the final step so DONE follows immediately.
            y_reg     <= y_calc;
            cnt_reg   <= '0;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_divider.sv
// Bench for ex_divider: directed vector table, randomized ops against an arithmetic model,
// and hand sequences for backpressure, flush and mid-operation reset.
module tb_ex_divider;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Arithmetic model: 64-bit truncating division and remainder, plus the divide-by-zero rules.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] d);
    longint sx, sd, q, r;
    if (d == 32'd0) return o[0] ? x : 32'hFFFF_FFFF;
    if (!o[1]) begin
      sx = longint'($signed(x));
      sd = longint'($signed(d));
    end else begin
      sx = longint'({32'd0, x});
      sd = longint'({32'd0, d});
    end
    q = sx / sd;
    r = sx % sd;
    return o[0] ? r[31:0] : q[31:0];
  endfunction

  // Called at a negedge; it returns at the negedge after the result handoff.
  task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        output logic [31:0] yy, output int lat);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    yy = y;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    $display("op=%0d a=%08h b=%08h y=%08h lat=%0d", o, aa, bb, yy, lat);
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] held;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;
    int          sel;

    vecs[0]  = '{2'd2, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{2'd0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33};
    vecs[3]  = '{2'd1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
    vecs[4]  = '{2'd1, 32'd100,        32'hFFFF_FFF9,  32'd2,          33};
    vecs[5]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
    vecs[6]  = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[7]  = '{2'd2, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[8]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{2'd3, 32'h0000_1234,  32'd0,          32'h0000_1234,  1};
    vecs[10] = '{2'd1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FF9C,  1};
    vecs[11] = '{2'd2, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          33};
    vecs[12] = '{2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33};
    vecs[13] = '{2'd0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33};

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_y", y, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, got, lat);
      check($sformatf("vec%0d_y", i), got, vecs[i].y);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Hold the result for five cycles while a competing request is offered.
    start_op(2'd2, 32'd1000, 32'd10);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd33);
    held = y;
    check("bp_y", held, 32'd100);
    for (int i = 0; i < 5; i++) begin
      op = 2'd3; a = 32'd77; b = 32'd5; in_valid = 1'b1;
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_y", y, 32'd100);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    $display("op=2 a=000003e8 b=0000000a y=%08h held 5 cycles", held);
    run_op(2'd3, 32'd77, 32'd5, got, lat);
    check("b2b_y", got, 32'd2);
    check("b2b_lat", 32'(lat), 32'd33);

    // Flush at CALC cycle 10 aborts the operation.
    start_op(2'd2, 32'd50, 32'd5);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    watch_no_valid("flush_no_result", 40);
    $display("flush at calc cycle 10: operation aborted");

    // A request coinciding with flush is dropped.
    op = 2'd2; a = 32'd9; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_in_ready", 32'(in_ready), 32'd1);
    watch_no_valid("flush_accept_no_result", 40);
    $display("in_valid with flush: not accepted");

    // Asynchronous reset at CALC cycle 20.
    start_op(2'd0, 32'hFFFF_0000, 32'd3);
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", y, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    watch_no_valid("rst_no_result", 40);
    $display("reset at calc cycle 20: operation aborted");
    run_op(2'd2, 32'd9, 32'd3, got, lat);
    check("post_abort_y", got, 32'd3);
    check("post_abort_lat", 32'(lat), 32'd33);

    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       begin ra = 32'h8000_0000; rb = $urandom; end
        4:       rb = ra >> $urandom_range(1, 31);
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, got, lat);
      check($sformatf("rand%0d_y", i), got, ref_div(ro, ra, rb));
      check($sformatf("rand%0d_lat", i), 32'(lat), (rb == 32'd0) ? 32'd1 : 32'd33);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
